// File: rtl/reg_file_writeback_arbiter.sv
// reg_file_writeback_arbiter
//   Writer-side front end for the register file's single write port. Result
//   sources (0 = ALU, 1 = load, 2 = mul/div) are arbitrated round-robin into
//   registered write_en/write_sel/write_data. A pending-write scoreboard lets
//   issue logic stall on registers that still have results outstanding.
//
// Ports
//   clk                    clock, all logic on posedge
//   rst                    synchronous active-high reset
//   in_src_valid           per-source write request
//   out_src_ready          per-source grant (combinational, one-hot or zero)
//   in_src_sel             per-source destination, source i at [i*SEL_WIDTH +: SEL_WIDTH]
//   in_src_data            per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_write_en/sel/data  registered register-file write port
//   in_reserve_en/sel      issue stage marks a destination as pending
//   out_pending            scoreboard, bit r set = write to r outstanding
//   out_err_double_reserve sticky: reserve of an already-pending register
//   out_stall_count        (only with OPT_REG_WB_STATS_EN) per-source 32-bit
//                          saturating count of valid && !ready cycles
//
// Optional feature macro: OPT_REG_WB_STATS_EN

module reg_file_writeback_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              in_src_valid,
  output logic [NUM_SRC-1:0]              out_src_ready,
  input  logic [NUM_SRC*SEL_WIDTH-1:0]    in_src_sel,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   in_src_data,
  output logic                            out_write_en,
  output logic [SEL_WIDTH-1:0]            out_write_sel,
  output logic [DATA_WIDTH-1:0]           out_write_data,
  input  logic                            in_reserve_en,
  input  logic [SEL_WIDTH-1:0]            in_reserve_sel,
  output logic [NUM_REGS-1:0]             out_pending,
  output logic                            out_err_double_reserve
`ifdef OPT_REG_WB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]           out_stall_count
`endif
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic                  grant_valid;
  logic [PTR_W-1:0]      grant_idx;
  logic [SEL_WIDTH-1:0]  grant_sel;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  clr_hit;
  logic                  res_hit;
  logic                  double_res;
  logic [NUM_REGS-1:0]   pending_next;
  int                    idx;

  // Round-robin search starting at rr_ptr. No grants while in reset so a
  // source never believes a transfer happened that the reset then drops.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    if (!rst) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_SRC;
        if (!grant_valid && in_src_valid[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = PTR_W'(idx);
        end
      end
    end
  end

  assign out_src_ready = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;
  assign grant_sel     = in_src_sel[int'(grant_idx)*SEL_WIDTH +: SEL_WIDTH];
  assign grant_data    = in_src_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Register 0 is hard zero: such writes are consumed but never reach the
  // register file or the scoreboard.
  assign clr_hit = grant_valid && (grant_sel != '0);
  assign res_hit = in_reserve_en && (in_reserve_sel != '0);

  // Clear first, then reserve, so a same-edge reserve wins.
  always_comb begin
    pending_next = out_pending;
    if (clr_hit) pending_next[grant_sel] = 1'b0;
    if (res_hit) pending_next[in_reserve_sel] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // A reserve that collides with the clearing write is a fresh reservation,
  // not a double one.
  assign double_res = res_hit && out_pending[in_reserve_sel]
                      && !(clr_hit && (grant_sel == in_reserve_sel));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr                 <= '0;
      out_write_en           <= 1'b0;
      out_write_sel          <= '0;
      out_write_data         <= '0;
      out_pending            <= '0;
      out_err_double_reserve <= 1'b0;
    end else begin
      out_write_en <= clr_hit;
      out_pending  <= pending_next;
      if (clr_hit) begin
        out_write_sel  <= grant_sel;
        out_write_data <= grant_data;
      end
      if (grant_valid) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      if (double_res) out_err_double_reserve <= 1'b1;
    end
  end

`ifdef OPT_REG_WB_STATS_EN
  logic [31:0] stall_cnt [NUM_SRC];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (in_src_valid[i] && !out_src_ready[i] && (stall_cnt[i] != 32'hFFFF_FFFF))
          stall_cnt[i] <= stall_cnt[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_stall_out
    assign out_stall_count[g*32 +: 32] = stall_cnt[g];
  end
`endif

endmodule

// File: tb/tb_reg_file_writeback_arbiter.sv
module tb_reg_file_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [11:0] src_sel;
  logic [95:0] src_data;
  logic        write_en;
  logic [3:0]  write_sel;
  logic [31:0] write_data;
  logic        reserve_en;
  logic [3:0]  reserve_sel;
  logic [15:0] pending;
  logic        err;
`ifdef OPT_REG_WB_STATS_EN
  logic [95:0] stall_count;
`endif

  int tests = 0;
  int fails = 0;

  reg_file_writeback_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .in_src_valid          (src_valid),
    .out_src_ready         (src_ready),
    .in_src_sel            (src_sel),
    .in_src_data           (src_data),
    .out_write_en          (write_en),
    .out_write_sel         (write_sel),
    .out_write_data        (write_data),
    .in_reserve_en         (reserve_en),
    .in_reserve_sel        (reserve_sel),
    .out_pending           (pending),
    .out_err_double_reserve(err)
`ifdef OPT_REG_WB_STATS_EN
    ,
    .out_stall_count       (stall_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_valid   = '0;
    src_sel     = '0;
    src_data    = '0;
    reserve_en  = 1'b0;
    reserve_sel = '0;
  endtask

  task automatic set_src(input int i, input logic [3:0] s, input logic [31:0] d);
    src_sel[i*4 +: 4]   = s;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = 3'b111;
    set_src(0, 4'd1, 32'h11);
    set_src(1, 4'd2, 32'h22);
    set_src(2, 4'd3, 32'h33);
    #1;
    tests++; if (src_ready !== 3'b000) begin fails++; $display("FAIL reset_ready: got %b want 000", src_ready); end
    step();
    step();
    tests++; if (write_en !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", write_en); end
    tests++; if (write_sel !== 4'd0) begin fails++; $display("FAIL reset_sel: got %h want 0", write_sel); end
    tests++; if (write_data !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", write_data); end
    tests++; if (pending !== 16'd0) begin fails++; $display("FAIL reset_pending: got %h want 0", pending); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    src_valid = 3'b010;
    set_src(1, 4'd5, 32'hDEADBEEF);
    #1;
    tests++; if (src_ready !== 3'b010) begin fails++; $display("FAIL single_ready: got %b want 010", src_ready); end
    step();
    clear_inputs();
    tests++; if (write_en !== 1'b1) begin fails++; $display("FAIL single_we: got %b want 1", write_en); end
    tests++; if (write_sel !== 4'd5) begin fails++; $display("FAIL single_sel: got %h want 5", write_sel); end
    tests++; if (write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h want deadbeef", write_data); end
    step();
    tests++; if (write_en !== 1'b0) begin fails++; $display("FAIL single_we_drop: got %b want 0", write_en); end
    tests++; if (write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data_hold: got %h want deadbeef", write_data); end
  endtask

  task automatic test_round_robin();
    int exp_g [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] exp_ready;
    do_reset();
    src_valid = 3'b111;
    set_src(0, 4'd1, 32'hA000_0000);
    set_src(1, 4'd2, 32'hA000_0001);
    set_src(2, 4'd3, 32'hA000_0002);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_ready = 3'b001 << exp_g[k];
      tests++; if (src_ready !== exp_ready) begin fails++; $display("FAIL rr_ready[%0d]: got %b want %b", k, src_ready, exp_ready); end
      step();
      tests++; if (write_en !== 1'b1 || write_sel !== 4'(exp_g[k] + 1) || write_data !== (32'hA000_0000 + 32'(exp_g[k])))
        begin fails++; $display("FAIL rr_write[%0d]: got en=%b sel=%h data=%h want en=1 sel=%0d data=%h", k, write_en, write_sel, write_data, exp_g[k] + 1, 32'hA000_0000 + 32'(exp_g[k])); end
    end
    clear_inputs();
    step();
    tests++; if (write_en !== 1'b0) begin fails++; $display("FAIL rr_idle_we: got %b want 0", write_en); end
    tests++; if (pending !== 16'd0) begin fails++; $display("FAIL rr_pending: got %h want 0", pending); end
  endtask

  task automatic test_reg0();
    do_reset();
    reserve_en = 1'b1;
    reserve_sel = 4'd3;
    step();
    clear_inputs();
    tests++; if (pending !== 16'h0008) begin fails++; $display("FAIL reg0_pre_pending: got %h want 0008", pending); end
    src_valid = 3'b001;
    set_src(0, 4'd0, 32'h1234);
    #1;
    tests++; if (src_ready !== 3'b001) begin fails++; $display("FAIL reg0_ready: got %b want 001", src_ready); end
    step();
    clear_inputs();
    tests++; if (write_en !== 1'b0) begin fails++; $display("FAIL reg0_we: got %b want 0", write_en); end
    tests++; if (pending !== 16'h0008) begin fails++; $display("FAIL reg0_pending: got %h want 0008", pending); end
    // rr_ptr now 1: with all sources requesting, source 1 must win.
    src_valid = 3'b111;
    set_src(0, 4'd1, 32'h1);
    set_src(1, 4'd2, 32'h2);
    set_src(2, 4'd4, 32'h3);
    #1;
    tests++; if (src_ready !== 3'b010) begin fails++; $display("FAIL reg0_rr_ptr: got %b want 010", src_ready); end
    step();
    clear_inputs();
  endtask

  task automatic test_scoreboard();
    // Reserve once, idle, then write r7 while reserving r7: reserve wins, no error.
    do_reset();
    reserve_en = 1'b1;
    reserve_sel = 4'd7;
    step();
    clear_inputs();
    tests++; if (pending !== 16'h0080) begin fails++; $display("FAIL sb_reserve: got %h want 0080", pending); end
    step();
    reserve_en = 1'b1;
    reserve_sel = 4'd7;
    src_valid = 3'b100;
    set_src(2, 4'd7, 32'hCAFE_0007);
    #1;
    tests++; if (src_ready !== 3'b100) begin fails++; $display("FAIL sb_coll_ready: got %b want 100", src_ready); end
    step();
    clear_inputs();
    tests++; if (pending !== 16'h0080) begin fails++; $display("FAIL sb_coll_pending: got %h want 0080", pending); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL sb_coll_err: got %b want 0", err); end
    tests++; if (write_en !== 1'b1 || write_sel !== 4'd7) begin fails++; $display("FAIL sb_coll_write: got en=%b sel=%h want en=1 sel=7", write_en, write_sel); end

    // Reserve held for three cycles with the write on the third: second
    // reserve hits an already-pending register and raises the error.
    do_reset();
    reserve_en = 1'b1;
    reserve_sel = 4'd7;
    step();
    tests++; if (pending !== 16'h0080 || err !== 1'b0) begin fails++; $display("FAIL sb_held_1: got pend=%h err=%b want 0080 0", pending, err); end
    step();
    tests++; if (pending !== 16'h0080 || err !== 1'b1) begin fails++; $display("FAIL sb_held_2: got pend=%h err=%b want 0080 1", pending, err); end
    src_valid = 3'b100;
    set_src(2, 4'd7, 32'hCAFE_0007);
    step();
    clear_inputs();
    tests++; if (pending !== 16'h0080 || err !== 1'b1) begin fails++; $display("FAIL sb_held_3: got pend=%h err=%b want 0080 1", pending, err); end
    step();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL sb_err_sticky: got %b want 1", err); end

    // Plain reserve-then-write clears the bit.
    do_reset();
    reserve_en = 1'b1;
    reserve_sel = 4'd7;
    step();
    clear_inputs();
    step();
    src_valid = 3'b100;
    set_src(2, 4'd7, 32'h0000_0077);
    step();
    clear_inputs();
    tests++; if (pending !== 16'h0000) begin fails++; $display("FAIL sb_clear: got %h want 0000", pending); end
    tests++; if (write_en !== 1'b1 || write_data !== 32'h77) begin fails++; $display("FAIL sb_clear_write: got en=%b data=%h want en=1 data=77", write_en, write_data); end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    reserve_en = 1'b1;
    reserve_sel = 4'd4;
    step();
    step();
    clear_inputs();
    tests++; if (pending !== 16'h0010 || err !== 1'b1) begin fails++; $display("FAIL mid_setup: got pend=%h err=%b want 0010 1", pending, err); end
    src_valid = 3'b010;
    set_src(1, 4'd9, 32'h9);
    step();
    // rr_ptr is 2 now; assert reset with a request present.
    src_valid = 3'b010;
    set_src(1, 4'd9, 32'h99);
    rst = 1'b1;
    #1;
    tests++; if (src_ready !== 3'b000) begin fails++; $display("FAIL mid_ready: got %b want 000", src_ready); end
    step();
    rst = 1'b0;
    clear_inputs();
    tests++; if (write_en !== 1'b0) begin fails++; $display("FAIL mid_we: got %b want 0", write_en); end
    tests++; if (pending !== 16'd0) begin fails++; $display("FAIL mid_pending: got %h want 0", pending); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL mid_err: got %b want 0", err); end
    src_valid = 3'b111;
    set_src(0, 4'd1, 32'h1);
    set_src(1, 4'd2, 32'h2);
    set_src(2, 4'd3, 32'h3);
    #1;
    tests++; if (src_ready !== 3'b001) begin fails++; $display("FAIL mid_rr_ptr: got %b want 001", src_ready); end
    step();
    clear_inputs();
  endtask

`ifdef OPT_REG_WB_STATS_EN
  task automatic test_stats();
    do_reset();
    tests++; if (stall_count !== 96'd0) begin fails++; $display("FAIL stats_reset: got %h want 0", stall_count); end
    src_valid = 3'b111;
    set_src(0, 4'd1, 32'h1);
    set_src(1, 4'd2, 32'h2);
    set_src(2, 4'd3, 32'h3);
    // Grants 0,1,2,0: src0 stalls 2 cycles, src1 and src2 stall 3 each.
    step();
    tests++; if (stall_count[31:0] !== 32'd0) begin fails++; $display("FAIL stats_src0_granted: got %0d want 0", stall_count[31:0]); end
    step();
    step();
    step();
    clear_inputs();
    tests++; if (stall_count[31:0] !== 32'd2) begin fails++; $display("FAIL stats_src0: got %0d want 2", stall_count[31:0]); end
    tests++; if (stall_count[63:32] !== 32'd3) begin fails++; $display("FAIL stats_src1: got %0d want 3", stall_count[63:32]); end
    tests++; if (stall_count[95:64] !== 32'd3) begin fails++; $display("FAIL stats_src2: got %0d want 3", stall_count[95:64]); end
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_write();
    test_round_robin();
    test_reg0();
    test_scoreboard();
    test_midstream_reset();
`ifdef OPT_REG_WB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
